max7219_frame_sequencer: RTL and testbench
==========================================

MAX7219_FRAME_SEQUENCER -- requirements
Module: max7219_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_DEVICES, default 20, meaning the number of MAX7219 devices in the daisy chain.
REQ-002 SHALL have parameter REFRESH_CYCLES, default 4000000, meaning the number of idle clocks between frames.
REQ-003 SHALL have parameter INIT_INTENSITY, default 4'h0, meaning the intensity sent during the init sequence.
REQ-004 SHALL have one clock and one reset: i_Clk, input, 1, the sole clock, all logic on its rising edge; i_Rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_Wr, input, 1, framebuffer write strobe.
REQ-006 SHALL have port i_Dev, input, 5, device index of the write.
REQ-007 SHALL have port i_Row, input, 3, row index of the write.
REQ-008 SHALL have port i_Byte, input, 8, row pixels; bit 7 is column 0 (leftmost).
REQ-009 SHALL have port i_Intensity, input, 4, display intensity.
REQ-010 SHALL have port i_Busy, input, 1, busy flag from spi_max7219.
REQ-011 SHALL have port o_Data_Ready, output, 1, one-cycle data-valid pulse to spi_max7219.
REQ-012 SHALL have port o_Data, output, 16*NUM_DEVICES, chain word; MSB is shifted first.
REQ-013 SHALL have port o_Frame_Done, output, 1, one-cycle pulse after the row-7 word is issued.

Function
REQ-014 SHALL hold an NUM_DEVICES x 8 x 8-bit framebuffer; writes with i_Dev >= NUM_DEVICES SHALL be ignored.
REQ-015 SHALL write i_Byte to entry [i_Dev][i_Row] on the rising edge where i_Wr=1, in every state.
REQ-016 SHALL place device k in bits [16*(NUM_DEVICES-k)-1 -: 16] of each word, each 16-bit field being {4'h0, reg[3:0], data[7:0]}.
REQ-017 SHALL step through the FSM states SD_OFF (0xC/0x00), TEST_ON (0xF/0x01), NORMAL (0xC/0x01), DECODE (0x9/0x00), SCAN (0xB/0x07), TEST_OFF (0xF/0x00), INTENS (0xA/latched intensity), ROW0..ROW7 (reg 0x1..0x8, framebuffer row n), then WAIT.
REQ-018 SHALL give every device the same reg/data in each init word.
REQ-019 SHALL, in WAIT, count REFRESH_CYCLES clocks and then return to NORMAL; the init words from NORMAL onward are resent every frame.
REQ-020 SHALL latch i_Intensity on entry to INTENS on every pass after the first; the first pass SHALL use INIT_INTENSITY.
REQ-021 SHALL, in each word state with i_Busy=0 and no pulse on the previous cycle, load o_Data, assert o_Data_Ready for exactly one cycle and advance state on the same edge.
REQ-022 SHALL ignore i_Busy on the cycle after a pulse, so that the minimum pulse spacing is 2 clocks.
REQ-023 SHALL hold o_Data stable between pulses.
REQ-024 SHALL sample framebuffer contents at the edge that loads o_Data.
REQ-025 SHALL, on a same-edge write to the row being sampled, place the old value in o_Data; the new value appears in the next frame.
REQ-026 SHALL NOT advance the FSM while i_Busy=1; framebuffer writes still proceed.
REQ-027 SHALL pulse o_Frame_Done on the same cycle as the row-7 o_Data_Ready pulse.
REQ-028 SHALL keep the WAIT counter wide enough for REFRESH_CYCLES with no wrap; the counter SHALL clear on WAIT exit.

Reset
REQ-029 SHALL, on i_Rst=1 at a clock edge, set the state to SD_OFF, o_Data_Ready=0, o_Frame_Done=0, o_Data=0, WAIT counter=0 and latched intensity=INIT_INTENSITY.
REQ-030 SHALL preserve framebuffer contents through reset.
REQ-031 SHALL, on reset during a transfer, stop pulsing; after release, the first word is SD_OFF once i_Busy=0.
REQ-032 SHALL take i_Rst precedence over i_Wr on the same edge, dropping the write.

Verification
REQ-033 SHALL cover reset release with i_Busy held 0: pulses occur every 2 clocks; first word is 20 x 0x0C00, then 0x0F01, 0x0C01, 0x0900, 0x0B07, 0x0F00, 0x0A00.
REQ-034 SHALL cover a write of dev 0, row 3, 0xA5 and of dev 19, row 3, 0x3C: the ROW3 word has MSB field 0x04A5, LSB field 0x043C and all other fields 0x0400.
REQ-035 SHALL cover i_Busy high for 50 clocks after a pulse: no further pulse occurs until 1 clock after i_Busy falls, and o_Data is unchanged meanwhile.
REQ-036 SHALL cover REFRESH_CYCLES=10: o_Frame_Done pulses with the ROW7 word, the NORMAL word follows 10 WAIT clocks later, and i_Intensity=4'h9 yields an INTENS field of 0x0A09.
REQ-037 SHALL cover a write colliding with the ROW2 sample, old 0x00 and new 0xFF: this frame carries 0x0300 and the next frame carries 0x03FF.
REQ-038 SHALL cover i_Rst asserted mid-frame in ROW4: outputs clear next cycle, the framebuffer is retained and the sequence restarts at SD_OFF.

Source files
------------

// File: rtl/max7219_frame_sequencer.sv
// ---------------------------------------------------------------------------
// max7219_frame_sequencer
//
// Drives a daisy chain of MAX7219 LED matrix controllers through an
// spi_max7219 shifter. After reset it sends the full init sequence
// (shutdown off, display test on/off, decode, scan limit, intensity), then
// the eight row words taken from an internal framebuffer, then idles for
// REFRESH_CYCLES clocks and repeats from the "normal operation" word.
//
// Ports
//   i_Clk         sole clock, all logic on its rising edge
//   i_Rst         synchronous active-high reset
//   i_Wr          framebuffer write strobe
//   i_Dev         device index of the write (ignored if >= NUM_DEVICES)
//   i_Row         row index of the write
//   i_Byte        row pixels, bit 7 = leftmost column
//   i_Intensity   display intensity, picked up once per refresh frame
//   i_Busy        shifter busy flag
//   o_Data_Ready  one-cycle pulse: o_Data holds a new chain word
//   o_Data        chain word, device 0 in the top 16 bits, MSB shifted first
//   o_Frame_Done  one-cycle pulse alongside the row-7 word
// ---------------------------------------------------------------------------
module max7219_frame_sequencer #(
   parameter int         NUM_DEVICES    = 20,
   parameter int         REFRESH_CYCLES = 4000000,
   parameter logic [3:0] INIT_INTENSITY = 4'h0
) (
   input  logic                       i_Clk,
   input  logic                       i_Rst,
   input  logic                       i_Wr,
   input  logic [4:0]                 i_Dev,
   input  logic [2:0]                 i_Row,
   input  logic [7:0]                 i_Byte,
   input  logic [3:0]                 i_Intensity,
   input  logic                       i_Busy,
   output logic                       o_Data_Ready,
   output logic [16*NUM_DEVICES-1:0]  o_Data,
   output logic                       o_Frame_Done
);

   localparam int DEV_W       = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
   // Counter only has to reach REFRESH_CYCLES-1, so it never wraps.
   localparam int CNT_W       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int WAIT_LAST_I = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LAST_I);

   typedef enum logic [3:0] {
      ST_SD_OFF,
      ST_TEST_ON,
      ST_NORMAL,
      ST_DECODE,
      ST_SCAN,
      ST_TEST_OFF,
      ST_INTENS,
      ST_ROW0,
      ST_ROW1,
      ST_ROW2,
      ST_ROW3,
      ST_ROW4,
      ST_ROW5,
      ST_ROW6,
      ST_ROW7,
      ST_WAIT
   } state_t;

   state_t                     state;
   state_t                     next_state;
   logic [CNT_W-1:0]           wait_cnt;
   logic [3:0]                 intensity;
   logic                       first_pass;

   logic [7:0]                 fb [NUM_DEVICES][8];
   logic                       dev_ok;

   logic [3:0]                 word_reg;
   logic [7:0]                 word_data;
   logic                       row_word;
   logic [2:0]                 row_sel;
   logic [16*NUM_DEVICES-1:0]  word;
   logic                       issue;

   // Framebuffer: written in every state, never cleared by reset; a write on
   // the same edge as reset is dropped.
   assign dev_ok = (32'(i_Dev) < 32'(NUM_DEVICES));

   always_ff @(posedge i_Clk) begin
      if (i_Wr && !i_Rst && dev_ok) begin
         fb[i_Dev[DEV_W-1:0]][i_Row] <= i_Byte;
      end
   end

   // Register address / data for the current word and the state that follows.
   always_comb begin
      word_reg   = 4'h0;
      word_data  = 8'h00;
      row_word   = 1'b0;
      row_sel    = 3'd0;
      next_state = ST_WAIT;
      case (state)
         ST_SD_OFF:   begin word_reg = 4'hC; word_data = 8'h00; next_state = ST_TEST_ON;  end
         ST_TEST_ON:  begin word_reg = 4'hF; word_data = 8'h01; next_state = ST_NORMAL;   end
         ST_NORMAL:   begin word_reg = 4'hC; word_data = 8'h01; next_state = ST_DECODE;   end
         ST_DECODE:   begin word_reg = 4'h9; word_data = 8'h00; next_state = ST_SCAN;     end
         ST_SCAN:     begin word_reg = 4'hB; word_data = 8'h07; next_state = ST_TEST_OFF; end
         ST_TEST_OFF: begin word_reg = 4'hF; word_data = 8'h00; next_state = ST_INTENS;   end
         ST_INTENS:   begin word_reg = 4'hA; word_data = {4'h0, intensity}; next_state = ST_ROW0; end
         ST_ROW0:     begin word_reg = 4'h1; row_word = 1'b1; row_sel = 3'd0; next_state = ST_ROW1; end
         ST_ROW1:     begin word_reg = 4'h2; row_word = 1'b1; row_sel = 3'd1; next_state = ST_ROW2; end
         ST_ROW2:     begin word_reg = 4'h3; row_word = 1'b1; row_sel = 3'd2; next_state = ST_ROW3; end
         ST_ROW3:     begin word_reg = 4'h4; row_word = 1'b1; row_sel = 3'd3; next_state = ST_ROW4; end
         ST_ROW4:     begin word_reg = 4'h5; row_word = 1'b1; row_sel = 3'd4; next_state = ST_ROW5; end
         ST_ROW5:     begin word_reg = 4'h6; row_word = 1'b1; row_sel = 3'd5; next_state = ST_ROW6; end
         ST_ROW6:     begin word_reg = 4'h7; row_word = 1'b1; row_sel = 3'd6; next_state = ST_ROW7; end
         ST_ROW7:     begin word_reg = 4'h8; row_word = 1'b1; row_sel = 3'd7; next_state = ST_WAIT; end
         ST_WAIT:     next_state = ST_NORMAL;
         default:     next_state = ST_SD_OFF;
      endcase
   end

   // Chain word: device k occupies the k-th 16-bit field counted from the MSB
   // end, so device 0 is shifted out first and ends up at the far end.
   always_comb begin
      word = '0;
      for (int k = 0; k < NUM_DEVICES; k++) begin
         word[16*(NUM_DEVICES-k)-1 -: 16] =
            {4'h0, word_reg, row_word ? fb[k][row_sel] : word_data};
      end
   end

   // o_Data_Ready high means a pulse went out last cycle; the shifter's busy
   // flag may not have risen yet, so that cycle never issues.
   assign issue = !i_Busy && !o_Data_Ready && (state != ST_WAIT);

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state        <= ST_SD_OFF;
         o_Data_Ready <= 1'b0;
         o_Frame_Done <= 1'b0;
         o_Data       <= '0;
         wait_cnt     <= '0;
         intensity    <= INIT_INTENSITY;
         first_pass   <= 1'b1;
      end else begin
         o_Data_Ready <= 1'b0;
         o_Frame_Done <= 1'b0;
         if (state == ST_WAIT) begin
            if (wait_cnt == WAIT_LAST) begin
               wait_cnt <= '0;
               state    <= ST_NORMAL;
            end else begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end else if (issue) begin
            o_Data       <= word;
            o_Data_Ready <= 1'b1;
            o_Frame_Done <= (state == ST_ROW7);
            state        <= next_state;
            // Leaving TEST_OFF means entering INTENS; the very first pass
            // after reset keeps the power-up intensity.
            if (state == ST_TEST_OFF && !first_pass) begin
               intensity <= i_Intensity;
            end
            if (state == ST_INTENS) begin
               first_pass <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_max7219_frame_sequencer.sv
module tb_max7219_frame_sequencer;

   localparam int NDEV = 20;
   localparam int RC   = 10;
   localparam int DW   = 16 * NDEV;
   localparam int NSEQ = 15;   // words per pass: 7 init words + 8 rows

   logic          clk = 1'b0;
   logic          rst;
   logic          wr;
   logic [4:0]    dev;
   logic [2:0]    row;
   logic [7:0]    wbyte;
   logic [3:0]    inten;
   logic          busy;
   logic          o_Data_Ready;
   logic [DW-1:0] o_Data;
   logic          o_Frame_Done;

   always #5 clk = ~clk;

   max7219_frame_sequencer #(
      .NUM_DEVICES    (NDEV),
      .REFRESH_CYCLES (RC),
      .INIT_INTENSITY (4'h0)
   ) dut (
      .i_Clk        (clk),
      .i_Rst        (rst),
      .i_Wr         (wr),
      .i_Dev        (dev),
      .i_Row        (row),
      .i_Byte       (wbyte),
      .i_Intensity  (inten),
      .i_Busy       (busy),
      .o_Data_Ready (o_Data_Ready),
      .o_Data       (o_Data),
      .o_Frame_Done (o_Frame_Done)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: position in the word list of a pass, refresh gap count,
   // a shadow framebuffer and the intensity the next INTENS word will carry.
   logic [11:0]   init_tab [7];
   int            m_seq;
   int            m_gap;
   bit            m_rdy;
   bit            m_done;
   bit            m_first;
   logic [3:0]    m_int;
   logic [DW-1:0] m_data;
   logic [7:0]    m_fb [NDEV][8];

   logic [DW-1:0] p_data [$];
   int            p_cyc  [$];
   bit            p_done [$];

   function automatic logic [15:0] exp_field(int s, int k);
      logic [11:0] t;
      if (s >= 7) return {4'h0, 4'(s - 6), m_fb[k][s-7]};
      t = init_tab[s];
      if (s == 6) t[7:0] = {4'h0, m_int};
      return {4'h0, t};
   endfunction

   task automatic model_step();
      bit was;
      if (rst) begin
         m_seq = 0; m_gap = 0; m_rdy = 0; m_done = 0; m_first = 1;
         m_int = 4'h0; m_data = '0;
         return;
      end
      was    = m_rdy;
      m_rdy  = 0;
      m_done = 0;
      if (m_seq == NSEQ) begin
         m_gap++;
         if (m_gap == RC) begin m_gap = 0; m_seq = 2; end
      end else if (!busy && !was) begin
         if (m_seq == 5 && !m_first) m_int = inten;
         for (int k = 0; k < NDEV; k++) m_data[16*(NDEV-k)-1 -: 16] = exp_field(m_seq, k);
         if (m_seq == 6) m_first = 0;
         m_rdy  = 1;
         m_done = (m_seq == NSEQ - 1);
         m_seq++;
      end
      if (wr && dev < NDEV) m_fb[dev][row] = wbyte;
   endtask

   task automatic check_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
      end
   endtask

   task automatic check_i(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d want %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: bound expired at cyc %0d", nm, cyc);
   endtask

   // One clock: advance model with the held inputs, then compare off-edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      check_w("ready", DW'(o_Data_Ready), DW'(m_rdy));
      check_w("frame_done", DW'(o_Frame_Done), DW'(m_done));
      check_w("data", o_Data, m_data);
      if (o_Data_Ready === 1'b1) begin
         p_data.push_back(o_Data);
         p_cyc.push_back(cyc);
         p_done.push_back(o_Frame_Done);
      end
   endtask

   task automatic clear_log();
      p_data.delete();
      p_cyc.delete();
      p_done.delete();
   endtask

   task automatic run_until_seq(input int s, input int limit);
      int n = 0;
      while (!(m_seq == s && !m_rdy) && n < limit) begin tick(); n++; end
      if (n >= limit) timeout("reach_word");
   endtask

   task automatic run_pulses(input int cnt, input int limit);
      int n = 0;
      while (p_data.size() < cnt && n < limit) begin tick(); n++; end
      if (n >= limit) timeout("pulse_count");
   endtask

   function automatic logic [DW-1:0] pd(int i);
      return (i < p_data.size()) ? p_data[i] : 'x;
   endfunction

   function automatic int pc(int i);
      return (i < p_cyc.size()) ? p_cyc[i] : -1000;
   endfunction

   function automatic logic [15:0] fld(logic [DW-1:0] w, int k);
      return w[16*(NDEV-k)-1 -: 16];
   endfunction

   initial begin
      int base;
      init_tab = '{12'hC00, 12'hF01, 12'hC01, 12'h900, 12'hB07, 12'hF00, 12'hA00};
      for (int d = 0; d < NDEV; d++) for (int r = 0; r < 8; r++) m_fb[d][r] = 8'h00;
      m_seq = 0; m_gap = 0; m_rdy = 0; m_done = 0; m_first = 1; m_int = 4'h0; m_data = '0;
      rst = 1; wr = 0; dev = 0; row = 0; wbyte = 0; inten = 4'h9; busy = 1;

      // Reset state
      repeat (3) tick();
      check_w("rst_data", o_Data, '0);
      check_w("rst_ready", DW'(o_Data_Ready), '0);

      // Stalled FSM while the framebuffer is brought to a known state
      rst = 0;
      for (int d = 0; d < NDEV; d++) begin
         for (int r = 0; r < 8; r++) begin
            wr = 1; dev = 5'(d); row = 3'(r); wbyte = 8'h00;
            tick();
         end
      end
      wr = 0;
      check_i("stall_no_pulse", p_data.size(), 0);

      // Release with busy low; two row-3 writes, then a write colliding with ROW2
      rst = 1; tick();
      rst = 0; busy = 0; clear_log();
      wr = 1; dev = 5'd0;  row = 3'd3; wbyte = 8'hA5; tick();
      dev = 5'd19; wbyte = 8'h3C; tick();
      wr = 0;
      run_until_seq(9, 100);
      wr = 1; dev = 5'd5; row = 3'd2; wbyte = 8'hFF; tick();
      wr = 0;
      run_pulses(23, 200);

      check_w("sd_off_word", pd(0), {NDEV{16'h0C00}});
      check_i("pulse_spacing", pc(1) - pc(0), 2);
      check_w("test_on_word", pd(1), {NDEV{16'h0F01}});
      check_w("normal_word", pd(2), {NDEV{16'h0C01}});
      check_w("decode_word", pd(3), {NDEV{16'h0900}});
      check_w("scan_word", pd(4), {NDEV{16'h0B07}});
      check_w("test_off_word", pd(5), {NDEV{16'h0F00}});
      check_w("intens_first", pd(6), {NDEV{16'h0A00}});
      check_w("row3_word", pd(10), {16'h04A5, {(NDEV-2){16'h0400}}, 16'h043C});
      check_w("row2_collide_old", DW'(fld(pd(9), 5)), DW'(16'h0300));
      check_i("done_row6", int'(p_done.size() > 13 ? p_done[13] : 1'b1), 0);
      check_i("done_row7", int'(p_done.size() > 14 ? p_done[14] : 1'b0), 1);
      check_i("refresh_gap", pc(15) - pc(14), RC + 1);
      check_w("normal_frame2", pd(15), {NDEV{16'h0C01}});
      check_w("intens_frame2", pd(19), {NDEV{16'h0A09}});
      check_w("row2_collide_new", DW'(fld(pd(22), 5)), DW'(16'h03FF));

      // Busy held high for 50 clocks right after a pulse
      busy = 1;
      base = p_data.size();
      repeat (50) tick();
      check_i("busy_no_pulse", p_data.size(), base);
      busy = 0;
      tick();
      check_w("busy_release_pulse", DW'(o_Data_Ready), DW'(1'b1));
      check_i("busy_release_gap", pc(base) - pc(base - 1), 51);

      // Reset in the middle of ROW4, with a write on the same edge
      run_until_seq(11, 100);
      rst = 1; wr = 1; dev = 5'd7; row = 3'd1; wbyte = 8'h55;
      tick();
      check_w("midreset_data", o_Data, '0);
      check_w("midreset_ready", DW'(o_Data_Ready), '0);
      rst = 0; wr = 0; clear_log();
      run_pulses(11, 100);
      check_w("restart_sd_off", pd(0), {NDEV{16'h0C00}});
      check_w("write_dropped", DW'(fld(pd(8), 7)), DW'(16'h0200));
      check_w("fb_retained", DW'(fld(pd(10), 0)), DW'(16'h04A5));

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         busy  = ($urandom_range(0, 9) < 4);
         wr    = ($urandom_range(0, 2) == 0);
         dev   = 5'($urandom_range(0, 31));
         row   = 3'($urandom);
         wbyte = 8'($urandom);
         if ($urandom_range(0, 49) == 0) inten = 4'($urandom);
         rst   = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 0; wr = 0; busy = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
